dot_product_engine: RTL and testbench

- Streaming fixed-point dot-product unit for the pixel/weight datapath.
- Each beat carries LANES pixel/weight pairs, and a vector may span any number of beats (end marked by in_last).
- Pipelined multiplier per lane; ADD_LAT-way interleaved accumulator banks per lane hide adder latency.
- Banks and lanes reduce to one VAL_SIZE result, delivered over a valid/ready output handshake.

---
 rtl/dot_product_engine_pkg.sv | 40 ++++
 rtl/dot_product_engine_if.sv | 29 ++
 rtl/dot_product_engine_lane.sv | 72 +++++++
 rtl/dot_product_engine.sv | 99 +++++++++
 tb/tb_dot_product_engine.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dot_product_engine_pkg.sv
// rtl/dot_product_engine_pkg.sv - shared defaults, derived widths and state encoding for the dot-product engine
package dp_pkg;

  localparam int DEF_PIXEL_SIZE  = 10;
  localparam int DEF_WEIGHT_SIZE = 19;
  localparam int DEF_VAL_SIZE    = 26;
  localparam int DEF_LANES       = 2;
  localparam int DEF_MUL_LAT     = 6;
  localparam int DEF_ADD_LAT     = 2;
  localparam int DEF_FRAC_SHIFT  = 0;

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_REDUCE = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  // Ceiling log2 with a floor of 1 so single-entry counters still get a bit
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Full signed product width: signed weight times zero-extended pixel
  function automatic int prod_width(input int ws, input int ps);
    return ws + ps + 1;
  endfunction

  // Bank pointer width for a lane with n banks
  function automatic int bp_width(input int n);
    return clog2(n);
  endfunction

endpackage

// File: rtl/dot_product_engine_if.sv
// rtl/dot_product_engine_if.sv - beat input, result output and status signals of the dot-product engine
interface dot_product_engine_if
  import dp_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int PIXEL_SIZE  = DEF_PIXEL_SIZE,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
  parameter int VAL_SIZE    = DEF_VAL_SIZE
);
  logic                           in_valid;
  logic                           in_ready;
  logic                           in_last;
  logic [LANES*PIXEL_SIZE-1:0]    in_pixels;
  logic [LANES*WEIGHT_SIZE-1:0]   in_weights;
  logic                           out_valid;
  logic                           out_ready;
  logic [VAL_SIZE-1:0]            out_value;
  logic                           busy;

  modport master (
    output in_valid, in_last, in_pixels, in_weights, out_ready,
    input  in_ready, out_valid, out_value, busy
  );

  modport slave (
    input  in_valid, in_last, in_pixels, in_weights, out_ready,
    output in_ready, out_valid, out_value, busy
  );
endinterface

// File: rtl/dot_product_engine_lane.sv
// rtl/dot_product_engine_lane.sv - one lane: pipelined multiplier feeding interleaved accumulator banks
module dp_lane
  import dp_pkg::*;
#(
  parameter int PIXEL_SIZE  = DEF_PIXEL_SIZE,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
  parameter int VAL_SIZE    = DEF_VAL_SIZE,
  parameter int MUL_LAT     = DEF_MUL_LAT,
  parameter int ADD_LAT     = DEF_ADD_LAT,
  parameter int FRAC_SHIFT  = DEF_FRAC_SHIFT
) (
  input  logic                        clk,
  input  logic                        GlobalReset,
  input  logic                        i_valid,
  input  logic                        i_clear,
  input  logic [PIXEL_SIZE-1:0]       i_pixel,
  input  logic [WEIGHT_SIZE-1:0]      i_weight,
  output logic [ADD_LAT*VAL_SIZE-1:0] o_banks
);
  localparam int PROD_W = prod_width(WEIGHT_SIZE, PIXEL_SIZE);
  localparam int BP_W   = bp_width(ADD_LAT);

  logic signed [PROD_W-1:0] w_wext;
  logic signed [PROD_W-1:0] w_pext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shift;
  logic        [VAL_SIZE-1:0] w_trunc;

  logic [VAL_SIZE-1:0] r_pipe [MUL_LAT];
  logic [MUL_LAT-1:0]  r_pv;
  logic [VAL_SIZE-1:0] r_bank [ADD_LAT];
  logic [BP_W-1:0]     r_bp;

  assign w_wext  = {{(PROD_W-WEIGHT_SIZE){i_weight[WEIGHT_SIZE-1]}}, i_weight};
  assign w_pext  = {{(PROD_W-PIXEL_SIZE){1'b0}}, i_pixel};
  assign w_prod  = w_wext * w_pext;
  assign w_shift = w_prod >>> FRAC_SHIFT;
  assign w_trunc = VAL_SIZE'(w_shift);

  // Multiplier pipeline: product and its valid bit march MUL_LAT stages together
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
      r_pv <= '0;
    end else begin
      r_pipe[0] <= w_trunc;
      r_pv[0]   <= i_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
        r_pv[i]   <= r_pv[i-1];
      end
    end
  end

  // Round-robin banks: each valid product lands in the next bank; bubbles leave bp alone
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int i = 0; i < ADD_LAT; i++) r_bank[i] <= '0;
      r_bp <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < ADD_LAT; i++) r_bank[i] <= '0;
      r_bp <= '0;
    end else if (r_pv[MUL_LAT-1]) begin
      r_bank[r_bp] <= r_bank[r_bp] + r_pipe[MUL_LAT-1];
      r_bp         <= (r_bp == BP_W'(ADD_LAT-1)) ? '0 : r_bp + 1'b1;
    end
  end

  for (genvar b = 0; b < ADD_LAT; b++) begin : g_bank
    assign o_banks[b*VAL_SIZE +: VAL_SIZE] = r_bank[b];
  end
endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - streaming multi-lane dot-product engine with drain, reduce and held output
module dot_product_engine
  import dp_pkg::*;
#(
  parameter int PIXEL_SIZE  = DEF_PIXEL_SIZE,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
  parameter int VAL_SIZE    = DEF_VAL_SIZE,
  parameter int LANES       = DEF_LANES,
  parameter int MUL_LAT     = DEF_MUL_LAT,
  parameter int ADD_LAT     = DEF_ADD_LAT,
  parameter int FRAC_SHIFT  = DEF_FRAC_SHIFT
) (
  input  logic               clk,
  input  logic               GlobalReset,
  dot_product_engine_if.slave bus
);
  localparam int DRAIN_N = MUL_LAT + ADD_LAT;
  localparam int CNT_W   = clog2(DRAIN_N + 1);

  logic [1:0]                         r_state;
  logic [CNT_W-1:0]                   r_cnt;
  logic [VAL_SIZE-1:0]                r_out_value;
  logic                               r_busy;
  logic                               w_accept;
  logic                               w_clear;
  logic [LANES*ADD_LAT*VAL_SIZE-1:0]  w_banks;
  logic [VAL_SIZE-1:0]                w_sum;

  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.out_valid = (r_state == ST_OUTPUT);
  assign bus.out_value = r_out_value;
  assign bus.busy      = r_busy;
  assign w_accept      = bus.in_valid && (r_state == ST_ACCUM);
  assign w_clear       = bus.out_ready && (r_state == ST_OUTPUT);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dp_lane #(
      .PIXEL_SIZE (PIXEL_SIZE),
      .WEIGHT_SIZE(WEIGHT_SIZE),
      .VAL_SIZE   (VAL_SIZE),
      .MUL_LAT    (MUL_LAT),
      .ADD_LAT    (ADD_LAT),
      .FRAC_SHIFT (FRAC_SHIFT)
    ) u_lane (
      .clk        (clk),
      .GlobalReset(GlobalReset),
      .i_valid    (w_accept),
      .i_clear    (w_clear),
      .i_pixel    (bus.in_pixels[k*PIXEL_SIZE +: PIXEL_SIZE]),
      .i_weight   (bus.in_weights[k*WEIGHT_SIZE +: WEIGHT_SIZE]),
      .o_banks    (w_banks[k*ADD_LAT*VAL_SIZE +: ADD_LAT*VAL_SIZE])
    );
  end

  // Wrapping sum of every bank in every lane
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES*ADD_LAT; i++) begin
      w_sum = w_sum + w_banks[i*VAL_SIZE +: VAL_SIZE];
    end
  end

  // Control: accept beats, wait out the pipelines, register the sum, hold it until taken
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_out_value <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (bus.in_last) begin
              r_state <= ST_DRAIN;
              r_cnt   <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (r_cnt == CNT_W'(DRAIN_N)) r_state <= ST_REDUCE;
          else                          r_cnt   <= r_cnt + 1'b1;
        end
        ST_REDUCE: begin
          r_out_value <= w_sum;
          r_state     <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            r_state <= ST_ACCUM;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_engine.sv
// tb/tb_dot_product_engine.sv - self-checking bench for dot_product_engine
module tb_dot_product_engine;
  localparam int PS   = 10;
  localparam int WS   = 19;
  localparam int VS   = 26;
  localparam int LN   = 2;
  localparam int ML   = 6;
  localparam int AL   = 2;
  localparam int FS   = 0;
  localparam int LAT  = ML + AL + 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [LN*PS-1:0] q_pix[$];
  logic [LN*WS-1:0] q_wt[$];

  typedef struct {
    int                     nb;
    logic [7:0][LN*PS-1:0]  pix;
    logic [7:0][LN*WS-1:0]  wt;
    bit                     gaps;
    int                     hold;
    logic [VS-1:0]          exp;
  } vec_t;

  vec_t tbl[4];

  dot_product_engine_if #(.LANES(LN), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .VAL_SIZE(VS)) bus ();

  dot_product_engine #(
    .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .VAL_SIZE(VS), .LANES(LN),
    .MUL_LAT(ML), .ADD_LAT(AL), .FRAC_SHIFT(FS)
  ) dut (
    .clk        (clk),
    .GlobalReset(rst),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: sum of signed(weight) * unsigned(pixel), shifted, modulo 2^VS
  function automatic logic [VS-1:0] model();
    longint acc;
    longint p;
    logic [WS-1:0] w;
    logic [PS-1:0] x;
    acc = 0;
    for (int b = 0; b < q_pix.size(); b++) begin
      for (int l = 0; l < LN; l++) begin
        w = q_wt[b][l*WS +: WS];
        x = q_pix[b][l*PS +: PS];
        p = longint'($signed(w)) * longint'({1'b0, x});
        acc = acc + (p >>> FS);
      end
    end
    return acc[VS-1:0];
  endfunction

  task automatic run_vec(input string nm, input bit gaps, input int hold, input logic [VS-1:0] exp);
    int n;
    int cyc;
    bit bub_ok;
    bit stable;
    logic [VS-1:0] v;
    n = q_pix.size();
    bub_ok = 1'b1;
    for (int b = 0; b < n; b++) begin
      bus.in_valid   = 1'b1;
      bus.in_pixels  = q_pix[b];
      bus.in_weights = q_wt[b];
      bus.in_last    = (b == n - 1);
      cyc = 0;
      while (bus.in_ready !== 1'b1 && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (cyc >= 50) check({nm, " in_ready timeout"}, 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (gaps && b != n - 1) begin
        if (bus.in_ready !== 1'b1) bub_ok = 1'b0;
        @(posedge clk); #1;
        if (bus.in_ready !== 1'b1) bub_ok = 1'b0;
      end
    end
    if (gaps) check({nm, " in_ready during bubbles"}, 64'(bub_ok), 64'd1);
    check({nm, " in_ready after last"}, 64'(bus.in_ready), 64'd0);
    check({nm, " busy after last"}, 64'(bus.busy), 64'd1);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " latency"}, 64'(cyc), 64'(LAT));
    check({nm, " value"}, 64'(bus.out_value), 64'(exp));
    v = bus.out_value;
    if (hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b1 || bus.out_value !== v || bus.in_ready !== 1'b0) stable = 1'b0;
      end
      check({nm, " held under backpressure"}, 64'(stable), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({nm, " out_valid after take"}, 64'(bus.out_valid), 64'd0);
    check({nm, " in_ready after take"}, 64'(bus.in_ready), 64'd1);
    check({nm, " busy after take"}, 64'(bus.busy), 64'd0);
    q_pix.delete();
    q_wt.delete();
  endtask

  initial begin
    logic [63:0] r;
    bit quiet;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_pixels = '0;
    bus.in_weights = '0;
    bus.out_ready = 1'b0;

    tbl[0].nb = 2; tbl[0].gaps = 0; tbl[0].hold = 0; tbl[0].exp = 26'd20;
    tbl[0].pix[0] = {10'd2, 10'd1}; tbl[0].wt[0] = {19'd2, 19'd2};
    tbl[0].pix[1] = {10'd4, 10'd3}; tbl[0].wt[1] = {19'd2, 19'd2};
    tbl[1].nb = 1; tbl[1].gaps = 0; tbl[1].hold = 0; tbl[1].exp = 26'h3FFFF06;
    tbl[1].pix[0] = {10'd50, 10'd100}; tbl[1].wt[0] = {19'd1, 19'h7FFFD};
    tbl[2].nb = 7; tbl[2].gaps = 1; tbl[2].hold = 0; tbl[2].exp = 26'd14;
    for (int b = 0; b < 7; b++) begin
      tbl[2].pix[b] = {10'd1, 10'd1};
      tbl[2].wt[b]  = {19'd1, 19'd1};
    end
    tbl[3] = tbl[0];
    tbl[3].hold = 20;

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_value", 64'(bus.out_value), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < tbl[t].nb; b++) begin
        q_pix.push_back(tbl[t].pix[b]);
        q_wt.push_back(tbl[t].wt[b]);
      end
      run_vec($sformatf("table%0d", t), tbl[t].gaps, tbl[t].hold, tbl[t].exp);
    end

    for (int b = 0; b < 64; b++) begin
      q_pix.push_back({10'd1023, 10'd1023});
      q_wt.push_back({19'd262143, 19'd262143});
    end
    run_vec("wrap", 1'b0, 0, model());

    for (int t = 0; t < 8; t++) begin
      int nb;
      nb = int'($urandom_range(1, 6));
      for (int b = 0; b < nb; b++) begin
        r = {$urandom, $urandom};
        q_pix.push_back(r[LN*PS-1:0]);
        r = {$urandom, $urandom};
        q_wt.push_back(r[LN*WS-1:0]);
      end
      run_vec($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), model());
    end

    bus.in_valid   = 1'b1;
    bus.in_last    = 1'b1;
    bus.in_pixels  = {10'd7, 10'd9};
    bus.in_weights = {19'd3, 19'd3};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset in_ready", 64'(bus.in_ready), 64'd1);
    check("midreset busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) quiet = 1'b0;
    end
    check("midreset no output pulse", 64'(quiet), 64'd1);
    q_pix.push_back({10'd0, 10'd5});
    q_wt.push_back({19'd0, 19'd4});
    run_vec("after reset", 1'b0, 0, 26'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
